// File: rtl/pmem_burst_responder_if.sv
// Cache-line burst bus between a requester (cache/arbiter) and a physical-memory responder.
// The requester drives strobes, address and write beats; the responder returns resp, read beats and a sticky error.
interface pmem_burst_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        pmem_proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, pmem_proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, pmem_proto_err
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Line-organised memory that answers each read/write request after LATENCY idle cycles
// with a four-beat 64-bit burst, and flags requester protocol violations.
module pmem_burst_responder #(
  parameter int LINE_BITS = 6,
  parameter int LATENCY   = 4
) (
  input logic                  clk,
  input logic                  rst,
  pmem_burst_responder_if.slave bus
);

  localparam int            NLINES = 1 << LINE_BITS;
  localparam logic [7:0]    LAT    = 8'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_op_wr;
  logic [LINE_BITS-1:0]   r_line;
  logic [26:0]            r_tag;
  logic [7:0]             r_cnt;
  logic [1:0]             r_beat;
  logic                   r_resp;
  logic                   r_err;
  logic [63:0]            r_mem [NLINES*4];

  logic [LINE_BITS+1:0]   w_idx;
  logic                   w_we;
  logic                   w_viol;
  logic                   w_unused;

  assign w_idx    = {r_line, r_beat};
  assign w_we     = (r_state == S_BURST) && r_op_wr;
  assign w_unused = ^bus.pmem_address[4:0];

  // Requester must hold its own strobe, keep the other low and keep the line address stable.
  assign w_viol = (r_op_wr ? (!bus.pmem_write || bus.pmem_read)
                           : (!bus.pmem_read  || bus.pmem_write))
                  || (bus.pmem_address[31:5] != r_tag);

  assign bus.pmem_resp      = r_resp;
  assign bus.pmem_proto_err = r_err;
  assign bus.pmem_rdata     = (r_resp && !r_op_wr) ? r_mem[w_idx] : 64'd0;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op_wr <= 1'b0;
      r_line  <= '0;
      r_tag   <= '0;
      r_cnt   <= 8'd0;
      r_beat  <= 2'd0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pmem_read && bus.pmem_write) begin
            r_err <= 1'b1;
          end else if (bus.pmem_read || bus.pmem_write) begin
            r_op_wr <= bus.pmem_write;
            r_line  <= bus.pmem_address[LINE_BITS+4:5];
            r_tag   <= bus.pmem_address[31:5];
            r_cnt   <= LAT;
            r_beat  <= 2'd0;
            if (LAT == 8'd0) begin
              r_state <= S_BURST;
              r_resp  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_viol) r_err <= 1'b1;
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= S_BURST;
            r_resp  <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_viol) r_err <= 1'b1;
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_state <= S_DONE;
            r_resp  <= 1'b0;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the line array is deliberately not reset; an aborted burst keeps the beats it already wrote.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= bus.pmem_wdata;
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Scoreboard bench: drivers push expected beats (cycle + data) from a line-array model; monitors pop on every resp.
module tb_pmem_burst_responder;

  localparam int LB    = 6;
  localparam int NL    = 1 << LB;
  localparam int LAT_A = 4;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_burst_responder_if bus_a ();
  pmem_burst_responder_if bus_b ();

  pmem_burst_responder #(.LINE_BITS(LB), .LATENCY(LAT_A)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pmem_burst_responder #(.LINE_BITS(LB), .LATENCY(LAT_B)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } beat_t;

  beat_t       q_a[$];
  beat_t       q_b[$];
  logic [63:0] model [NL][4];
  bit          known [NL];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every resp cycle must match the oldest expected beat in time and data.
  always @(negedge clk) begin
    beat_t it;
    if (bus_a.pmem_resp === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_resp", {63'd0, bus_a.pmem_resp}, 64'd0);
      end else begin
        it = q_a.pop_front();
        check("a_beat_cycle", 64'(cyc), 64'(it.cyc));
        check("a_rdata", bus_a.pmem_rdata, it.data);
      end
    end
  end

  always @(negedge clk) begin
    beat_t it;
    if (bus_b.pmem_resp === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_resp", {63'd0, bus_b.pmem_resp}, 64'd0);
      end else begin
        it = q_b.pop_front();
        check("b_beat_cycle", 64'(cyc), 64'(it.cyc));
        check("b_rdata", bus_b.pmem_rdata, it.data);
      end
    end
  end

  task automatic set_req(input int sel, input logic rd, input logic wr, input logic [31:0] addr);
    if (sel == 0) begin
      bus_a.pmem_read = rd; bus_a.pmem_write = wr; bus_a.pmem_address = addr;
    end else begin
      bus_b.pmem_read = rd; bus_b.pmem_write = wr; bus_b.pmem_address = addr;
    end
  endtask

  task automatic set_wdata(input int sel, input logic [63:0] d);
    if (sel == 0) bus_a.pmem_wdata = d;
    else          bus_b.pmem_wdata = d;
  endtask

  task automatic push_exp(input int sel, input int c, input logic [63:0] d);
    beat_t it;
    it.cyc  = c;
    it.data = d;
    if (sel == 0) q_a.push_back(it);
    else          q_b.push_back(it);
  endtask

  // One complete burst at the earliest legal slot; optionally moves the address mid-WAIT.
  task automatic burst(input int sel, input bit wr, input logic [31:0] addr,
                       input logic [63:0] wd [4], input bit corrupt);
    int lat;
    int c;
    int line;
    lat  = (sel == 0) ? LAT_A : LAT_B;
    line = int'(addr >> 5) % NL;
    @(negedge clk);
    c = cyc;
    set_req(sel, !wr, wr, addr);
    for (int k = 0; k < 4; k++) begin
      push_exp(sel, c + lat + 1 + k, wr ? 64'd0 : model[line][k]);
      if (wr) model[line][k] = wd[k];
    end
    if (wr) known[line] = 1'b1;
    if (corrupt) begin
      while (cyc < c + 2) @(negedge clk);
      set_req(sel, !wr, wr, addr ^ 32'h40);
    end
    for (int k = 0; k < 4; k++) begin
      while (cyc < c + lat + 1 + k) @(negedge clk);
      set_wdata(sel, wr ? wd[k] : {$urandom, $urandom});
    end
    while (cyc < c + lat + 5) @(negedge clk);
    set_req(sel, 1'b0, 1'b0, addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] wd [4];
    logic [31:0] addr;
    bit          wr;
    int          line;
    int          c;

    set_req(0, 1'b0, 1'b0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0);
    set_wdata(0, 64'd0);
    set_wdata(1, 64'd0);

    // Reset values, during reset and in the first cycle after release
    repeat (3) @(negedge clk);
    check("rst_resp",  {63'd0, bus_a.pmem_resp}, 64'd0);
    check("rst_rdata", bus_a.pmem_rdata, 64'd0);
    check("rst_err",   {63'd0, bus_a.pmem_proto_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_resp",  {63'd0, bus_a.pmem_resp}, 64'd0);
    check("post_rst_rdata", bus_a.pmem_rdata, 64'd0);
    check("post_rst_err",   {63'd0, bus_a.pmem_proto_err}, 64'd0);

    // Directed write then read of line 0x40
    wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    burst(0, 1'b1, 32'h0000_0040, wd, 1'b0);
    burst(0, 1'b0, 32'h0000_0040, wd, 1'b0);

    // Aliasing: 0x820 maps to the same line as 0x20
    wd = '{64'hDEAD_BEEF_0000_0001, 64'h0, 64'h1, 64'h2};
    burst(0, 1'b1, 32'h0000_0020, wd, 1'b0);
    burst(0, 1'b0, 32'h0000_0820, wd, 1'b0);

    // Randomized back-to-back traffic over a few lines with random upper/low address bits
    for (int i = 0; i < 40; i++) begin
      line = $urandom_range(0, 7);
      addr = ($urandom & 32'hFFFF_F81F) | (32'(line) << 5);
      wr   = 1'($urandom_range(0, 1));
      if (!known[line]) wr = 1'b1;
      for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
      burst(0, wr, addr, wd, 1'b0);
    end
    @(negedge clk);
    check("a_err_clean_traffic", {63'd0, bus_a.pmem_proto_err}, 64'd0);

    // Both strobes high in IDLE: no resp (monitor) and sticky error
    set_req(0, 1'b1, 1'b1, 32'h0000_0100);
    repeat (20) @(negedge clk);
    check("a_err_both_high", {63'd0, bus_a.pmem_proto_err}, 64'd1);
    set_req(0, 1'b0, 1'b0, 32'h0000_0100);
    rst = 1'b1;
    @(negedge clk);
    check("a_err_cleared_by_rst", {63'd0, bus_a.pmem_proto_err}, 64'd0);
    rst = 1'b0;

    // Address moves mid-WAIT: data still comes from the latched line, error sets
    burst(0, 1'b0, 32'h0000_0040, wd, 1'b1);
    @(negedge clk);
    check("a_err_addr_change", {63'd0, bus_a.pmem_proto_err}, 64'd1);
    @(negedge clk);
    check("a_err_sticky", {63'd0, bus_a.pmem_proto_err}, 64'd1);

    // Reset abort of a write over line 5 after beat 1
    for (int k = 0; k < 4; k++) wd[k] = 64'hAAAA_AAAA_AAAA_AAA0 + 64'(k);
    burst(0, 1'b1, 32'h0000_00A0, wd, 1'b0);
    for (int k = 0; k < 4; k++) wd[k] = 64'h5555_0000_0000_0000 + 64'(k);
    @(negedge clk);
    c = cyc;
    set_req(0, 1'b0, 1'b1, 32'h0000_00A0);
    push_exp(0, c + LAT_A + 1, 64'd0);
    push_exp(0, c + LAT_A + 2, 64'd0);
    model[5][0] = wd[0];
    model[5][1] = wd[1];
    while (cyc < c + LAT_A + 1) @(negedge clk);
    set_wdata(0, wd[0]);
    @(negedge clk);
    set_wdata(0, wd[1]);
    @(posedge clk);
    #1;
    check("a_resp_before_abort", {63'd0, bus_a.pmem_resp}, 64'd1);
    rst = 1'b1;
    #1;
    check("a_resp_async_drop", {63'd0, bus_a.pmem_resp}, 64'd0);
    check("a_rdata_async_drop", bus_a.pmem_rdata, 64'd0);
    set_req(0, 1'b0, 1'b0, 32'h0000_00A0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_post_resp", {63'd0, bus_a.pmem_resp}, 64'd0);
    check("abort_post_err",  {63'd0, bus_a.pmem_proto_err}, 64'd0);
    burst(0, 1'b0, 32'h0000_00A0, wd, 1'b0);

    // LATENCY=0 instance: fill a line, then two reads with the strobe held through DONE
    for (int k = 0; k < 4; k++) wd[k] = {$urandom, $urandom};
    burst(1, 1'b1, 32'h0000_0060, wd, 1'b0);
    @(negedge clk);
    c = cyc;
    set_req(1, 1'b1, 1'b0, 32'h0000_0060);
    for (int k = 0; k < 4; k++) push_exp(1, c + 1 + k, model[3][k]);
    for (int k = 0; k < 4; k++) push_exp(1, c + 7 + k, model[3][k]);
    while (cyc < c + 11) @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("b_err_clean", {63'd0, bus_b.pmem_proto_err}, 64'd0);

    repeat (4) @(negedge clk);
    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
